// File: rtl/i2c_stuck_detect.sv
// I2C stuck-SDA detector: times SDA low with SCL high on the slow tick and pulses
// start toward i2c_bus_reset, with bounded retries. Optional SCL-low monitor: I2C_STUCK_DETECT_SCL_MONITOR_EN.
module i2c_stuck_detect #(
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned HOLDOFF     = 32,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       enable,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       start,
  output logic       stuck,
  output logic [2:0] retries,
  output logic       fail
`ifdef I2C_STUCK_DETECT_SCL_MONITOR_EN
  ,
  output logic       scl_stuck
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] HO_LAST   = CNT_WIDTH'(HOLDOFF - 1);
  localparam logic [2:0]           RETRY_MAX = 3'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_FAILED  = 2'd3
  } state_t;

  logic                 sda_meta_r, sda_s;
  logic                 scl_meta_r, scl_s;
  state_t               state_r, state_nx_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_nx_s;
  logic [2:0]           retries_nx_s;
  logic                 start_nx_s, stuck_nx_s, fail_nx_s;
  logic                 sda_stuck_s, bus_free_s;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_meta_r <= 1'b1;
      sda_s      <= 1'b1;
      scl_meta_r <= 1'b1;
      scl_s      <= 1'b1;
    end else begin
      sda_meta_r <= sda_in;
      sda_s      <= sda_meta_r;
      scl_meta_r <= scl_in;
      scl_s      <= scl_meta_r;
    end
  end

  assign sda_stuck_s = ~sda_s & scl_s;
  assign bus_free_s  = sda_s & scl_s;

  // Next-state, counter, retry and output decode
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    retries_nx_s = retries;
    if (!enable) begin
      state_nx_s   = ST_IDLE;
      cnt_nx_s     = CNT_ZERO;
      retries_nx_s = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus_free_s) begin
            retries_nx_s = 3'd0;
          end else begin
            retries_nx_s = retries;
          end
          // A lost condition clears the count even on a tick cycle
          if (!sda_stuck_s) begin
            cnt_nx_s = CNT_ZERO;
          end else if (ce) begin
            if (cnt_r == TO_LAST) begin
              cnt_nx_s = CNT_ZERO;
              if (retries == RETRY_MAX) begin
                state_nx_s = ST_FAILED;
              end else begin
                state_nx_s   = ST_PULSE;
                retries_nx_s = retries + 3'd1;
              end
            end else begin
              cnt_nx_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        ST_PULSE: begin
          state_nx_s = ST_HOLDOFF;
          cnt_nx_s   = CNT_ZERO;
        end
        ST_HOLDOFF: begin
          if (ce) begin
            if (cnt_r == HO_LAST) begin
              state_nx_s = ST_IDLE;
              cnt_nx_s   = CNT_ZERO;
            end else begin
              cnt_nx_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        ST_FAILED: begin
          state_nx_s = ST_FAILED;
          cnt_nx_s   = CNT_ZERO;
        end
        default: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end

    start_nx_s = (state_nx_s == ST_PULSE);
    fail_nx_s  = (state_nx_s == ST_FAILED);
    stuck_nx_s = (state_nx_s == ST_PULSE) || (state_nx_s == ST_HOLDOFF) ||
                 ((state_nx_s == ST_IDLE) && (cnt_nx_s != CNT_ZERO));
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      retries <= 3'd0;
      start   <= 1'b0;
      stuck   <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      retries <= retries_nx_s;
      start   <= start_nx_s;
      stuck   <= stuck_nx_s;
      fail    <= fail_nx_s;
    end
  end

`ifdef I2C_STUCK_DETECT_SCL_MONITOR_EN
  logic [CNT_WIDTH-1:0] scl_cnt_r;

  // SCL-low timer; report only, never drives the recovery FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_cnt_r <= CNT_ZERO;
      scl_stuck <= 1'b0;
    end else if (!enable || scl_s) begin
      scl_cnt_r <= CNT_ZERO;
      scl_stuck <= 1'b0;
    end else if (ce) begin
      if (scl_cnt_r == TO_LAST) begin
        scl_stuck <= 1'b1;
      end else begin
        scl_cnt_r <= scl_cnt_r + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2c_stuck_detect.sv
// Directed bench for i2c_stuck_detect: TIMEOUT=8, HOLDOFF=4, MAX_RETRIES=2, ce every 10 clk.
module tb_i2c_stuck_detect;
  localparam int TIMEOUT     = 8;
  localparam int HOLDOFF     = 4;
  localparam int MAX_RETRIES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       enable = 1'b1;
  logic       sda_in = 1'b1;
  logic       scl_in = 1'b1;
  logic       start, stuck, fail;
  logic [2:0] retries;
`ifdef I2C_STUCK_DETECT_SCL_MONITOR_EN
  logic       scl_stuck;
`endif

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int double_cnt = 0;
  logic prev_start = 1'b0;
  int base;

  i2c_stuck_detect #(
    .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF), .MAX_RETRIES(MAX_RETRIES), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(enable),
    .sda_in(sda_in), .scl_in(scl_in),
    .start(start), .stuck(stuck), .retries(retries), .fail(fail)
`ifdef I2C_STUCK_DETECT_SCL_MONITOR_EN
    , .scl_stuck(scl_stuck)
`endif
  );

  always #5 clk = ~clk;

  // ce high for exactly one sampling edge out of every ten
  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 ce = 1'b1;
      @(posedge clk);
      #1 ce = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (start && prev_start) double_cnt <= double_cnt + 1;
    if (start) start_cnt <= start_cnt + 1;
    prev_start <= start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!ce);
    end
  endtask

  // Returns just after a tick edge once ce has dropped again
  task automatic align();
    wait_ticks(1);
    #2;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", int'(start), 0);
    check("rst_stuck", int'(stuck), 0);
    check("rst_retries", int'(retries), 0);
    check("rst_fail", int'(fail), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = start_cnt;
    repeat (200) @(posedge clk);
    check("post_rst_no_start", start_cnt - base, 0);
    check("post_rst_stuck", int'(stuck), 0);
    check("post_rst_fail", int'(fail), 0);

    // Single recovery
    align();
    sda_in = 1'b0;
    base = start_cnt;
    wait_ticks(7);
    @(negedge clk);
    check("single_pre_start", int'(start), 0);
    check("single_pre_stuck", int'(stuck), 1);
    wait_ticks(1);
    @(negedge clk);
    check("single_start", int'(start), 1);
    check("single_retries", int'(retries), 1);
    check("single_stuck", int'(stuck), 1);
    @(negedge clk);
    check("single_start_width", int'(start), 0);
    sda_in = 1'b1;
    wait_ticks(6);
    check("single_rel_retries", int'(retries), 0);
    check("single_rel_stuck", int'(stuck), 0);
    check("single_pulse_count", start_cnt - base, 1);

    // Glitch filter
    align();
    base = start_cnt;
    sda_in = 1'b0;
    wait_ticks(7);
    @(negedge clk);
    check("glitch_stuck_7", int'(stuck), 1);
    sda_in = 1'b1;
    wait_ticks(1);
    #2 sda_in = 1'b0;
    wait_ticks(7);
    #2 sda_in = 1'b1;
    wait_ticks(3);
    check("glitch_no_start", start_cnt - base, 0);
    check("glitch_stuck_clr", int'(stuck), 0);

    // Retry exhaustion
    align();
    base = start_cnt;
    sda_in = 1'b0;
    wait_ticks(8);
    @(negedge clk);
    check("exh_start1", int'(start), 1);
    check("exh_retries1", int'(retries), 1);
    wait_ticks(11);
    @(negedge clk);
    check("exh_gap_no_start", start_cnt - base, 1);
    wait_ticks(1);
    @(negedge clk);
    check("exh_start2", int'(start), 1);
    check("exh_retries2", int'(retries), 2);
    wait_ticks(11);
    @(negedge clk);
    check("exh_fail_early", int'(fail), 0);
    wait_ticks(1);
    @(negedge clk);
    check("exh_fail", int'(fail), 1);
    check("exh_fail_stuck", int'(stuck), 0);
    check("exh_fail_start", int'(start), 0);
    wait_ticks(20);
    check("exh_pulse_count", start_cnt - base, 2);
    check("exh_fail_hold", int'(fail), 1);
    check("exh_retries_sat", int'(retries), 2);
    @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    check("exh_en_fail_clr", int'(fail), 0);
    check("exh_en_retries_clr", int'(retries), 0);
    sda_in = 1'b1;
    wait_ticks(2);

    // Reset mid-pulse
    align();
    sda_in = 1'b0;
    wait_ticks(8);
    #2;
    check("rmp_start_hi", int'(start), 1);
    rst_n = 1'b0;
    #1;
    check("rmp_start_async", int'(start), 0);
    sda_in = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    check("rmp_retries", int'(retries), 0);
    check("rmp_stuck", int'(stuck), 0);
    align();
    sda_in = 1'b0;
    wait_ticks(8);
    @(negedge clk);
    check("rmp_idle_restart", int'(start), 1);
    check("rmp_idle_retries", int'(retries), 1);
    sda_in = 1'b1;
    wait_ticks(6);
    check("rmp_final_retries", int'(retries), 0);

`ifdef I2C_STUCK_DETECT_SCL_MONITOR_EN
    // SCL monitor
    align();
    base = start_cnt;
    scl_in = 1'b0;
    wait_ticks(7);
    @(negedge clk);
    check("scl_pre", int'(scl_stuck), 0);
    wait_ticks(1);
    @(negedge clk);
    check("scl_stuck_set", int'(scl_stuck), 1);
    check("scl_no_sda_stuck", int'(stuck), 0);
    @(posedge clk);
    #1 scl_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("scl_stuck_clr", int'(scl_stuck), 0);
    check("scl_no_start", start_cnt - base, 0);
`endif

    check("no_double_start", double_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
